// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
// Holds the FSM state encoding and the modulo-N index increment.
package burst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        return (nxt >= n) ? 32'd0 : nxt;
    endfunction

endpackage

// File: rtl/burst_rr_arbiter_if.sv
// Beat-level bus between the requesters, the arbiter and the downstream sink.
// The arbiter connects through the slave modport, the environment through master.
interface burst_rr_arbiter_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 8
);
    localparam int IdxWidth = $clog2(NumIn);
    localparam int CntWidth = $clog2(MaxBurst + 1);

    logic [NumIn-1:0]                req_i;
    logic [NumIn-1:0]                last_i;
    logic [NumIn-1:0][DataWidth-1:0] data_i;
    logic [NumIn-1:0]                gnt_o;
    logic                            req_o;
    logic                            gnt_i;
    logic [DataWidth-1:0]            data_o;
    logic                            last_o;
    logic [IdxWidth-1:0]             idx_o;
    logic [CntWidth-1:0]             beat_cnt_o;
    logic                            overlong_o;

    modport slave (
        input  req_i, last_i, data_i, gnt_i,
        output gnt_o, req_o, data_o, last_o, idx_o, beat_cnt_o, overlong_o
    );

    modport master (
        output req_i, last_i, data_i, gnt_i,
        input  gnt_o, req_o, data_o, last_o, idx_o, beat_cnt_o, overlong_o
    );

endinterface

// File: rtl/burst_rr_arbiter_rr_arb_tree.sv
// Round-robin request picker: first requester at or after the priority index.
// Priority comes from rr_i (ExtPrio) or an internal pointer; LockIn holds a stalled pick.
module rr_arb_tree
    import burst_arb_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter bit ExtPrio   = 1'b0,
    parameter bit AxiVldRdy = 1'b0,
    parameter bit LockIn    = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [$clog2(NumIn)-1:0] rr_i,
    input  logic [NumIn-1:0]         req_i,
    input  logic                     gnt_i,
    output logic                     req_o,
    output logic [NumIn-1:0]         gnt_o,
    output logic [$clog2(NumIn)-1:0] idx_o
);
    localparam int IdxWidth = $clog2(NumIn);

    logic [IdxWidth-1:0] rr_r;
    logic [IdxWidth-1:0] lock_idx_r;
    logic                locked_r;
    logic [IdxWidth-1:0] prio_s;
    logic [IdxWidth-1:0] pick_s;
    logic                found_s;
    logic                hit_s;
    int unsigned         cand_s;

    // Scan from the priority index upward, wrapping, and keep the first hit
    always_comb begin
        prio_s  = ExtPrio ? rr_i : rr_r;
        pick_s  = prio_s;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 32'd0;
        for (int unsigned off = 0; off < NumIn; off++) begin
            cand_s  = 32'(prio_s) + off;
            cand_s  = (cand_s >= 32'(NumIn)) ? cand_s - 32'(NumIn) : cand_s;
            hit_s   = !found_s && req_i[cand_s[IdxWidth-1:0]];
            pick_s  = hit_s ? cand_s[IdxWidth-1:0] : pick_s;
            found_s = found_s | hit_s;
        end
    end

    // Drive the decision, honouring a held pick while locked
    always_comb begin
        idx_o = (LockIn && locked_r) ? lock_idx_r : pick_s;
        req_o = (LockIn && locked_r) ? req_i[lock_idx_r] : (|req_i);
        gnt_o = {NumIn{1'b0}};
        for (int k = 0; k < NumIn; k++) begin
            gnt_o[k] = gnt_i & (idx_o == IdxWidth'(k)) & (AxiVldRdy | req_o);
        end
    end

    // Internal priority pointer and stall lock
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rr_r       <= {IdxWidth{1'b0}};
            lock_idx_r <= {IdxWidth{1'b0}};
            locked_r   <= 1'b0;
        end else if (req_o && gnt_i) begin
            rr_r     <= IdxWidth'(wrap_inc(32'(idx_o), 32'(NumIn)));
            locked_r <= 1'b0;
        end else if (req_o) begin
            locked_r   <= LockIn;
            lock_idx_r <= idx_o;
        end
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Burst-aware round-robin arbiter: a requester keeps the output from its first
// beat until its last beat; bursts reaching MaxBurst beats are flagged once.
module burst_rr_arbiter
    import burst_arb_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    burst_rr_arbiter_if.slave   bus
);
    localparam int IdxWidth = $clog2(NumIn);
    localparam int CntWidth = $clog2(MaxBurst + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxBurst);

    state_e              state_r;
    state_e              state_s;
    logic [IdxWidth-1:0] rr_r;
    logic [IdxWidth-1:0] lock_r;
    logic [CntWidth-1:0] cnt_r;
    logic                ovl_r;

    logic [IdxWidth-1:0] tree_idx_s;
    logic                tree_req_s;
    logic [NumIn-1:0]    tree_gnt_s;
    logic [NumIn-1:0]    held_gnt_s;
    logic [IdxWidth-1:0] sel_idx_s;
    logic                sel_req_s;
    logic                sel_last_s;
    logic                hs_s;
    logic                hs_last_s;

    rr_arb_tree #(
        .NumIn     (NumIn),
        .ExtPrio   (1'b1),
        .AxiVldRdy (1'b0),
        .LockIn    (1'b0)
    ) u_tree (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .rr_i    (rr_r),
        .req_i   (bus.req_i),
        .gnt_i   (bus.gnt_i),
        .req_o   (tree_req_s),
        .gnt_o   (tree_gnt_s),
        .idx_o   (tree_idx_s)
    );

    // Tree decides in IDLE; HOLD and BURST stay on the latched index
    always_comb begin
        if (state_r == IDLE) begin
            sel_idx_s = tree_idx_s;
            sel_req_s = tree_req_s;
        end else begin
            sel_idx_s = lock_r;
            sel_req_s = bus.req_i[lock_r];
        end
        sel_last_s = sel_req_s & bus.last_i[sel_idx_s];
        hs_s       = sel_req_s & bus.gnt_i;
        hs_last_s  = hs_s & sel_last_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = !sel_req_s  ? IDLE :
                               !bus.gnt_i  ? HOLD :
                               sel_last_s  ? IDLE : BURST;
            HOLD:    state_s = !hs_s       ? HOLD :
                               sel_last_s  ? IDLE : BURST;
            BURST:   state_s = hs_last_s   ? IDLE : BURST;
            default: state_s = IDLE;
        endcase
    end

    // State register; flush wins over any handshake in the same cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Priority pointer, lock index, beat counter and overlong pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rr_r   <= {IdxWidth{1'b0}};
            lock_r <= {IdxWidth{1'b0}};
            cnt_r  <= {CntWidth{1'b0}};
            ovl_r  <= 1'b0;
        end else begin
            if (state_r == IDLE && sel_req_s && !hs_last_s) begin
                lock_r <= tree_idx_s;
            end
            if (hs_last_s) begin
                rr_r <= IdxWidth'(wrap_inc(32'(sel_idx_s), 32'(NumIn)));
            end
            if (hs_last_s) begin
                cnt_r <= {CntWidth{1'b0}};
            end else if (hs_s && cnt_r != CntMax) begin
                cnt_r <= cnt_r + CntWidth'(1);
            end
            // Only the step from MaxBurst-1 fires, so a saturated burst pulses once
            ovl_r <= hs_s & ~sel_last_s & (cnt_r == CntMax - CntWidth'(1));
        end
    end

    // Output mux
    always_comb begin
        held_gnt_s = {NumIn{1'b0}};
        for (int k = 0; k < NumIn; k++) begin
            held_gnt_s[k] = hs_s & (lock_r == IdxWidth'(k));
        end
        bus.gnt_o      = (state_r == IDLE) ? tree_gnt_s : held_gnt_s;
        bus.req_o      = sel_req_s;
        bus.idx_o      = sel_idx_s;
        bus.last_o     = sel_last_s;
        bus.data_o     = sel_req_s ? bus.data_i[sel_idx_s] : {DataWidth{1'b0}};
        bus.beat_cnt_o = cnt_r;
        bus.overlong_o = ovl_r;
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter: a vector table plus hand-written
// flush and mid-burst reset sequences.
module tb_burst_rr_arbiter;
    import burst_arb_pkg::*;

    localparam int NumIn     = 4;
    localparam int DataWidth = 32;
    localparam int MaxBurst  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;

    burst_rr_arbiter_if #(.NumIn(NumIn), .DataWidth(DataWidth), .MaxBurst(MaxBurst)) bus ();

    burst_rr_arbiter #(.NumIn(NumIn), .DataWidth(DataWidth), .MaxBurst(MaxBurst)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       gnt;
        logic       e_req;
        logic [1:0] e_idx;
        logic [3:0] e_gnt;
        logic       e_last;
        logic [2:0] e_cnt;
        logic       e_ovl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] req, logic [3:0] last, logic gnt,
                                logic e_req, logic [1:0] e_idx, logic [3:0] e_gnt,
                                logic e_last, logic [2:0] e_cnt, logic e_ovl);
        vec_t v;
        v.req = req; v.last = last; v.gnt = gnt;
        v.e_req = e_req; v.e_idx = e_idx; v.e_gnt = e_gnt;
        v.e_last = e_last; v.e_cnt = e_cnt; v.e_ovl = e_ovl;
        return v;
    endfunction

    function automatic logic [31:0] payload(input logic [1:0] idx);
        return 32'hCAFE_0000 + 32'(idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // A requester stalled in HOLD must keep its request up
    task automatic check_hold();
        if (dut.state_r == HOLD) begin
            n_tests++;
            assert (bus.req_o)
            else begin
                n_fail++;
                $display("FAIL hold_req_drop: req_o=%0b, required 1", bus.req_o);
            end
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] last, input logic gnt);
        bus.req_i  = req;
        bus.last_i = last;
        bus.gnt_i  = gnt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [1:0] e_idx,
                             input logic [3:0] e_gnt, input logic e_last,
                             input logic [2:0] e_cnt, input logic e_ovl);
        check({tag, " req_o"},    32'(bus.req_o),      32'(e_req));
        check({tag, " idx_o"},    32'(bus.idx_o),      32'(e_idx));
        check({tag, " gnt_o"},    32'(bus.gnt_o),      32'(e_gnt));
        check({tag, " last_o"},   32'(bus.last_o),     32'(e_last));
        check({tag, " data_o"},   bus.data_o,          e_req ? payload(e_idx) : 32'h0);
        check({tag, " beat_cnt"}, 32'(bus.beat_cnt_o), 32'(e_cnt));
        check({tag, " overlong"}, 32'(bus.overlong_o), 32'(e_ovl));
        check({tag, " gnt_onehot0"}, 32'($onehot0(bus.gnt_o)), 32'd1);
        check_hold();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 ns, required earlier finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NumIn; k++) bus.data_i[k] = payload(2'(k));
        rst_n = 1'b0;
        flush = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0));
        // all requesting single-beat: plain rotation
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b1, 2'(i % 4), 4'(4'b0001 << (i % 4)),
                              1'b1, 3'd0, 1'b0));
        end
        // one beat from 1 moves priority to 2; then a 3-beat burst by 2 beside 0
        vecs.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 3'd1, 1'b0));
        vecs.push_back(mk(4'b0101, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 3'd2, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 3'd0, 1'b0));
        // HOLD on 1 while 0 (now highest priority) rises
        vecs.push_back(mk(4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0011, 4'b0011, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0011, 4'b0011, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0011, 4'b0011, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 3'd0, 1'b0));
        // overlong burst by 3 with stalls and a dropped request
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 3'd2, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 3'd3, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 3'd4, 1'b1));
        vecs.push_back(mk(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 3'd4, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 3'd4, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 3'd4, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].last, vecs[i].gnt);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_idx, vecs[i].e_gnt,
                      vecs[i].e_last, vecs[i].e_cnt, vecs[i].e_ovl);
            step();
        end

        // flush mid-burst with a simultaneous handshake
        drive(4'b0010, 4'b0010, 1'b1); step();
        drive(4'b0100, 4'b0000, 1'b1); step();
        drive(4'b0100, 4'b0000, 1'b1); step();
        flush = 1'b1;
        @(negedge clk);
        check_all("flush_edge", 1'b1, 2'd2, 4'b0100, 1'b0, 3'd2, 1'b0);
        step();
        flush = 1'b0;
        drive(4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        check_all("post_flush", 1'b1, 2'd0, 4'b0000, 1'b1, 3'd0, 1'b0);
        step();
        drive(4'b1111, 4'b1111, 1'b1);
        @(negedge clk);
        check_all("post_flush_hs", 1'b1, 2'd0, 4'b0001, 1'b1, 3'd0, 1'b0);
        step();

        // reset mid-burst
        drive(4'b0100, 4'b0000, 1'b1); step();
        step();
        @(negedge clk);
        check_all("pre_reset", 1'b1, 2'd2, 4'b0100, 1'b0, 3'd2, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        check_all("post_reset", 1'b1, 2'd0, 4'b0000, 1'b1, 3'd0, 1'b0);
        step();
        drive(4'b1111, 4'b1111, 1'b1);
        @(negedge clk);
        check_all("post_reset_hs", 1'b1, 2'd0, 4'b0001, 1'b1, 3'd0, 1'b0);
        step();
        drive(4'b0000, 4'b0000, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_rr_arbiter.md
BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

Interface
REQ-001 Parameter NumIn, default 4, number of requesters, SHALL be at least 2.
REQ-002 Parameter DataWidth, default 32, payload width per beat.
REQ-003 Parameter MaxBurst, default 8, beat count at which a burst is flagged as overlong; SHALL be at least 2.
REQ-004 Parameter IdxWidth, derived as $clog2(NumIn), SHALL NOT be overridden.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 flush_i  in  1  synchronous clear of arbiter state.
REQ-008 req_i  in  NumIn  per-requester beat valid.
REQ-009 last_i  in  NumIn  per-requester last-beat marker, qualified by req_i.
REQ-010 data_i  in  NumIn x DataWidth  per-requester beat payload.
REQ-011 gnt_o  out  NumIn  per-requester beat accepted.
REQ-012 req_o  out  1  output beat valid.
REQ-013 gnt_i  in  1  output beat accepted by downstream.
REQ-014 data_o  out  DataWidth  selected payload.
REQ-015 last_o  out  1  selected last marker.
REQ-016 idx_o  out  IdxWidth  index of the selected requester.
REQ-017 beat_cnt_o  out  $clog2(MaxBurst+1)  beats handshaken in the current burst, saturating at MaxBurst.
REQ-018 overlong_o  out  1  one-cycle registered pulse that flags an overlong burst.

Function
REQ-019 A beat handshake SHALL occur in a cycle with req_o=1 and gnt_i=1, and it SHALL apply only to requester idx_o.
REQ-020 The FSM SHALL have exactly three states: IDLE, HOLD and BURST.
REQ-021 In IDLE, the selected requester SHALL be req_i[rr_q] if set, otherwise any other requesting input, with the choice made combinationally in the same cycle.
REQ-022 IDLE with req_o=1 and gnt_i=0 SHALL transition to HOLD, latching the selected index; HOLD SHALL keep that index until a handshake occurs.
REQ-023 A handshake with last_o=0 in IDLE or HOLD SHALL transition to BURST, locking idx_o.
REQ-024 A handshake with last_o=1 in IDLE or HOLD SHALL transition to IDLE, and rr_q SHALL become (idx_o+1) mod NumIn.
REQ-025 In BURST, only the locked requester SHALL be selected: req_o=req_i[lock].
REQ-026 In BURST, deassertion of the locked req_i SHALL stall the burst without releasing the lock.
REQ-027 In BURST, a handshake with last_o=1 SHALL transition to IDLE, and rr_q SHALL become (lock+1) mod NumIn.
REQ-028 gnt_o[k] SHALL equal gnt_i AND req_o AND (k==idx_o); gnt_o SHALL be one-hot or zero.
REQ-029 data_o, last_o and idx_o SHALL follow the selected requester combinationally.
REQ-030 beat_cnt_o SHALL increment on each handshake, saturating at MaxBurst.
REQ-031 beat_cnt_o SHALL reset to 0 on the cycle after a last-beat handshake.
REQ-032 A handshake with last_o=0 that brings the count to MaxBurst SHALL raise overlong_o for exactly the next cycle.
REQ-033 The lock SHALL be kept after an overlong pulse; no further pulses SHALL occur in that burst.
REQ-034 A requester that drops req_i while in HOLD SHALL be treated as a protocol violation; the bench SHALL assert against it.
REQ-035 When flush_i=1, on the next edge the FSM SHALL enter IDLE, and rr_q, the lock, beat_cnt_o and overlong_o SHALL be set to 0; flush_i SHALL take precedence over a simultaneous handshake.
REQ-036 rr_q SHALL wrap from NumIn-1 to 0.

Reset
REQ-037 While rst_ni=0 at a rising edge, the FSM SHALL be set to IDLE, and rr_q, the lock index, beat_cnt_o and overlong_o SHALL be set to 0.
REQ-038 After reset with req_i=0, req_o, gnt_o, idx_o, data_o and last_o SHALL all be 0.
REQ-039 A reset asserted mid-burst SHALL abandon the burst; the first post-reset decision SHALL use priority index 0.

Structure
REQ-040 Package burst_arb_pkg SHALL hold the FSM state enum (IDLE, HOLD, BURST).
REQ-041 IDLE-state selection SHALL instantiate sub-module rr_arb_tree with ExtPrio=1, AxiVldRdy=0, LockIn=0 and rr_i=rr_q.
REQ-042 HOLD and BURST SHALL override the tree output with the latched index.
REQ-043 The FSM, counters, lock register and output mux override SHALL reside in burst_rr_arbiter.

Verification
REQ-044 NumIn=4, MaxBurst=4; all req_i=1, all last_i=1, gnt_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3, gnt_o one-hot each cycle.
REQ-045 req_i[2]=1 with last on its 3rd beat, req_i[0]=1 throughout, gnt_i=1 -> idx_o=2 for 3 consecutive handshakes, gnt_o[0]=0 meanwhile; next grant to 3 if requesting, else 0.
REQ-046 req_i[1]=1, gnt_i=0 for 3 cycles while req_i[0] rises -> idx_o stays 1 (HOLD); handshake on cycle 4 to requester 1 only.
REQ-047 Locked requester 3 sends 4 beats with last_i=0 -> overlong_o=1 for exactly one cycle after the 4th handshake; beat_cnt_o saturates at 4; lock holds until the last beat.
REQ-048 Mid-burst: flush_i=1 with simultaneous handshake -> next cycle FSM IDLE, beat_cnt_o=0, priority index 0.
REQ-049 Mid-burst: rst_ni=0 for one cycle -> next cycle FSM IDLE, beat_cnt_o=0, priority index 0.
